cache_perf_counter: RTL and testbench

Synthesisable performance monitor for the set-associative cache. It watches the CPU↔cache handshake (`cpu_to_cache` valid/rw, `cache_to_cpu` stopped/ready) and counts accesses, misses, stall cycles and read returns in saturating live counters. Software or a bench reads a snapshot bank through a registered select port. An optional fixed-length window mode makes it a periodic sampler, replacing the per-run counters previously kept only in simulation.

---
 rtl/cache_perf_counter.sv | 172 +++++++++++++++++
 tb/tb_cache_perf_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_perf_counter.sv
// -----------------------------------------------------------------------------
// cache_perf_counter
//
// Performance monitor for the set-associative cache. It watches the CPU<->cache
// handshake and keeps eight saturating live counters. A snapshot bank holds
// copies of those counters, and a registered select port reads them back. When
// window_len is non-zero, the block takes a snapshot and clears the live
// counters automatically every window_len enabled cycles.
//
// Counter index (the same numbering is used by rd_sel and ovf):
//   0 rd_acc   1 wr_acc   2 rd_miss   3 wr_miss
//   4 rd_stall 5 wr_stall 6 rd_ret    7 cycles
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-low reset
//   enable        in   1 = live counters and window counter advance
//   cpu_valid     in   CPU request valid
//   cpu_rw        in   request type, 0 = read, 1 = write
//   cache_stopped in   cache stall indication
//   cache_ready   in   read data returned
//   clear         in   pulse: zero live counters, window counter and ovf
//   snap          in   pulse: copy next-state live counters into the snapshot bank
//   window_len    in   window length in enabled cycles, 0 = window mode off
//   rd_sel        in   snapshot index to read
//   rd_data       out  registered snapshot value selected by rd_sel
//   snap_done     out  one-cycle pulse after any snapshot
//   ovf           out  sticky per-counter saturation flags
// -----------------------------------------------------------------------------
module cache_perf_counter #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cpu_valid,
  input  logic             cpu_rw,
  input  logic             cache_stopped,
  input  logic             cache_ready,
  input  logic             clear,
  input  logic             snap,
  input  logic [WIN_W-1:0] window_len,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             snap_done,
  output logic [7:0]       ovf
);

  localparam int IDX_RD_ACC   = 0;
  localparam int IDX_WR_ACC   = 1;
  localparam int IDX_RD_MISS  = 2;
  localparam int IDX_WR_MISS  = 3;
  localparam int IDX_RD_STALL = 4;
  localparam int IDX_WR_STALL = 5;
  localparam int IDX_RD_RET   = 6;
  localparam int IDX_CYCLES   = 7;

  logic [CNT_W-1:0] r_cnt    [8];
  logic [CNT_W-1:0] r_shadow [8];
  logic [WIN_W-1:0] r_win_cnt;
  logic             r_pend_rw;
  logic             r_prev_stopped;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_snap_done;
  logic [7:0]       r_ovf;

  logic [7:0]       w_inc;
  logic [7:0]       w_sat;
  logic [CNT_W-1:0] w_cnt_next [8];
  logic             w_accept;
  logic             w_miss;
  logic             w_win_last;
  logic             w_snap_any;
  logic             w_live_clr;

  assign w_accept = cpu_valid & ~cache_stopped;
  assign w_miss   = cache_stopped & ~r_prev_stopped;

  // Miss and stall events are charged to the access that r_pend_rw names. That
  // is the last request type seen while the cache was not stopped.
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_inc               = '0;
    w_inc[IDX_RD_ACC]   = w_accept & ~cpu_rw;
    w_inc[IDX_WR_ACC]   = w_accept &  cpu_rw;
    w_inc[IDX_RD_MISS]  = w_miss & ~r_pend_rw;
    w_inc[IDX_WR_MISS]  = w_miss &  r_pend_rw;
    w_inc[IDX_RD_STALL] = cache_stopped & ~r_pend_rw;
    w_inc[IDX_WR_STALL] = cache_stopped &  r_pend_rw;
    w_inc[IDX_RD_RET]   = cache_ready;
    w_inc[IDX_CYCLES]   = 1'b1;
    if (!enable) begin
      w_inc = '0;
    end
  end

  // Next-state value of each counter. An increment requested while the counter
  // is all-ones is dropped and flagged as a saturation event.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_sat[i]      = w_inc[i] & (&r_cnt[i]);
      w_cnt_next[i] = r_cnt[i];
      if (w_inc[i] && !w_sat[i]) begin
        w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // The comparison is >= rather than ==. If window_len shrinks below the
  // current count, the window closes on the next enabled cycle instead of
  // waiting for the counter to wrap.
  assign w_win_last = enable && (window_len != '0) &&
                      (r_win_cnt >= window_len - WIN_W'(1));
  assign w_snap_any = snap | w_win_last;
  assign w_live_clr = clear | w_win_last;

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the snapshot bank is a register array, not a RAM, and it must
      // read back 0 after reset, so it is reset explicitly.
      for (int i = 0; i < 8; i++) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
      end
      r_win_cnt      <= '0;
      r_pend_rw      <= 1'b0;
      r_prev_stopped <= 1'b0;
      r_rd_data      <= '0;
      r_snap_done    <= 1'b0;
      r_ovf          <= '0;
    end else begin
      // The handshake trackers follow the bus even while counting is disabled.
      r_prev_stopped <= cache_stopped;
      if (!cache_stopped) begin
        r_pend_rw <= cpu_rw;
      end

      for (int i = 0; i < 8; i++) begin
        if (w_snap_any) begin
          r_shadow[i] <= w_cnt_next[i];
        end
        r_cnt[i] <= w_live_clr ? '0 : w_cnt_next[i];
      end

      // A window end clears the live counters but leaves ovf set. Only an
      // explicit clear removes the sticky flags.
      if (clear) begin
        r_ovf <= '0;
      end else begin
        r_ovf <= r_ovf | w_sat;
      end

      if (w_live_clr || (window_len == '0)) begin
        r_win_cnt <= '0;
      end else if (enable) begin
        r_win_cnt <= r_win_cnt + WIN_W'(1);
      end

      r_snap_done <= w_snap_any;
      r_rd_data   <= r_shadow[rd_sel];
    end
  end

  assign rd_data   = r_rd_data;
  assign snap_done = r_snap_done;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cache_perf_counter.sv
// -----------------------------------------------------------------------------
// tb_cache_perf_counter
//
// Self-checking bench for cache_perf_counter. A behavioural model keeps the
// counters as plain integers and derives every output on every cycle. A set of
// directed scenarios pins that model to hand-computed values. A randomized
// phase then exercises windows, clears, snapshots and resets together.
// -----------------------------------------------------------------------------
module tb_cache_perf_counter;

  localparam int     CNT_W = 6;
  localparam int     WIN_W = 8;
  localparam longint MAXV  = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic             cpu_valid = 1'b0;
  logic             cpu_rw = 1'b0;
  logic             cache_stopped = 1'b0;
  logic             cache_ready = 1'b0;
  logic             clear = 1'b0;
  logic             snap = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic [2:0]       rd_sel = '0;
  logic [CNT_W-1:0] rd_data;
  logic             snap_done;
  logic [7:0]       ovf;

  always #5 clk = ~clk;

  cache_perf_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cpu_valid(cpu_valid),
    .cpu_rw(cpu_rw), .cache_stopped(cache_stopped), .cache_ready(cache_ready),
    .clear(clear), .snap(snap), .window_len(window_len), .rd_sel(rd_sel),
    .rd_data(rd_data), .snap_done(snap_done), .ovf(ovf)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_live   [8];
  longint m_shadow [8];
  bit [7:0] m_ovf;
  int       m_win;
  bit       m_prev_stop, m_pend;
  longint   m_rd;
  bit       m_done;
  bit       m_armed = 1'b0;

  always @(posedge clk) begin : model
    longint nxt [8];
    int     ev  [8];
    bit [7:0] sat;
    bit     acc, wend;
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        m_live[i] = 0;
        m_shadow[i] = 0;
      end
      m_ovf = '0; m_win = 0; m_prev_stop = 0; m_pend = 0;
      m_rd = 0; m_done = 0; m_armed = 1'b1;
    end else begin
      acc   = cpu_valid && !cache_stopped;
      ev[0] = (acc && !cpu_rw) ? 1 : 0;
      ev[1] = (acc &&  cpu_rw) ? 1 : 0;
      ev[2] = (cache_stopped && !m_prev_stop && !m_pend) ? 1 : 0;
      ev[3] = (cache_stopped && !m_prev_stop &&  m_pend) ? 1 : 0;
      ev[4] = (cache_stopped && !m_pend) ? 1 : 0;
      ev[5] = (cache_stopped &&  m_pend) ? 1 : 0;
      ev[6] = cache_ready ? 1 : 0;
      ev[7] = 1;
      sat = '0;
      for (int i = 0; i < 8; i++) begin
        if (!enable) ev[i] = 0;
        nxt[i] = m_live[i] + ev[i];
        if (nxt[i] > MAXV) begin
          nxt[i] = MAXV;
          sat[i] = 1'b1;
        end
      end
      wend = enable && (window_len != 0) && (m_win >= int'(window_len) - 1);

      m_rd   = m_shadow[rd_sel];
      m_done = snap || wend;
      for (int i = 0; i < 8; i++) begin
        if (snap || wend) m_shadow[i] = nxt[i];
        m_live[i] = (clear || wend) ? 0 : nxt[i];
      end
      m_ovf = clear ? 8'h00 : (m_ovf | sat);
      if (clear || wend || window_len == 0) m_win = 0;
      else if (enable) m_win = m_win + 1;
      if (!cache_stopped) m_pend = cpu_rw;
      m_prev_stop = cache_stopped;
    end
  end

  // Compare process: all outputs, every cycle after the first reset.
  always @(negedge clk) begin
    if (m_armed) begin
      check("rd_data",   64'(rd_data),   64'(m_rd));
      check("snap_done", 64'(snap_done), 64'(m_done));
      check("ovf",       64'(ovf),       64'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle();
    enable = 0; cpu_valid = 0; cpu_rw = 0; cache_stopped = 0;
    cache_ready = 0; clear = 0; snap = 0;
  endtask

  task automatic pulse_clear();
    idle(); clear = 1; tick(); clear = 0;
  endtask

  task automatic pulse_snap();
    idle(); snap = 1; tick(); snap = 0;
  endtask

  task automatic read_lit(input int idx, input longint exp, input string name);
    idle(); rd_sel = 3'(idx); tick();
    check(name, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  int exp1 [8] = '{5, 3, 0, 0, 0, 0, 0, 8};

  initial begin
    int pulses, got;
    // ---- reset, then 5 reads + 3 writes, then snap ----
    idle(); rst = 0; tick(2);
    check("reset_rd_data", 64'(rd_data), 0);
    check("reset_snap_done", 64'(snap_done), 0);
    check("reset_ovf", 64'(ovf), 0);
    rst = 1; enable = 1; cpu_valid = 1; cpu_rw = 0;
    tick(5);
    cpu_rw = 1;
    tick(3);
    pulse_snap();
    check("tp1_snap_done_hi", 64'(snap_done), 1);
    idle(); tick();
    check("tp1_snap_done_lo", 64'(snap_done), 0);
    for (int i = 0; i < 8; i++) read_lit(i, exp1[i], $sformatf("tp1_idx%0d", i));

    // ---- read miss with 4 stall cycles, write miss with 2 ----
    pulse_clear();
    enable = 1; cpu_valid = 1; cpu_rw = 0; cache_stopped = 0; tick();
    cache_stopped = 1; tick(4);
    cache_stopped = 0; cpu_rw = 1; tick();
    cache_stopped = 1; tick(2);
    pulse_snap();
    read_lit(2, 1, "tp2_rd_miss");
    read_lit(3, 1, "tp2_wr_miss");
    read_lit(4, 4, "tp2_rd_stall");
    read_lit(5, 2, "tp2_wr_stall");

    // ---- window of 10 ----
    pulse_clear();
    window_len = 10; enable = 1; cpu_valid = 1; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cpu_rw = 1'($urandom);
      tick();
      if (snap_done) pulses++;
    end
    check("tp3_pulses", 64'(pulses), 3);
    window_len = 0;
    read_lit(7, 10, "tp3_win_cycles");
    pulse_snap();
    read_lit(7, 0, "tp3_live_after_win");

    // ---- saturation ----
    pulse_clear();
    enable = 1; cpu_valid = 1; cpu_rw = 0; tick(70);
    pulse_snap();
    read_lit(0, MAXV, "tp4_rd_acc_sat");
    check("tp4_ovf0", 64'(ovf[0]), 1);
    check("tp4_ovf7", 64'(ovf[7]), 1);
    pulse_clear();
    check("tp4_ovf_cleared", 64'(ovf), 0);
    pulse_snap();
    read_lit(0, 0, "tp4_rd_acc_zero");

    // ---- snap + clear together with an accepted read ----
    pulse_clear();
    enable = 1; cpu_valid = 1; cpu_rw = 0; tick(6);
    snap = 1; clear = 1; tick(); snap = 0; clear = 0;
    read_lit(0, 7, "tp5_snap_rd_acc");
    pulse_snap();
    read_lit(0, 0, "tp5_live_cleared");

    // ---- reset mid-window during a stall ----
    pulse_clear();
    window_len = 10; enable = 1; cpu_valid = 1; cpu_rw = 0; tick(4);
    cache_stopped = 1; tick(2);
    rst = 0; tick();
    check("tp6_rd_data", 64'(rd_data), 0);
    check("tp6_snap_done", 64'(snap_done), 0);
    check("tp6_ovf", 64'(ovf), 0);
    rst = 1; cache_stopped = 0; got = -1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (snap_done) begin
        got = k;
        break;
      end
    end
    check("tp6_window_restart", 64'(got), 10);

    // ---- randomized phase ----
    window_len = 8'($urandom_range(0, 20));
    for (int n = 0; n < 4000; n++) begin
      rst           = ($urandom % 500) != 0;
      enable        = ($urandom % 8) != 0;
      cpu_valid     = 1'($urandom);
      cpu_rw        = 1'($urandom);
      if ($urandom % 4 == 0) cache_stopped = ~cache_stopped;
      cache_ready   = ($urandom % 3) == 0;
      clear         = ($urandom % 60) == 0;
      snap          = ($urandom % 15) == 0;
      rd_sel        = 3'($urandom);
      if ($urandom % 200 == 0) window_len = 8'($urandom_range(0, 20));
      tick();
    end

    idle(); rst = 1; tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
